hdr_shift_sched: RTL and testbench
==================================

# hdr_shift_sched

Pass scheduler for the parser's head/meta shift stage. It accepts one shift request per parse step: header and metadata consume lengths, in shift units of `SHIFT_WIDTH` bits. It splits each request into one or more passes that the shift stage can execute, since one pass moves at most `HEAD_CANDI_NUM-1` head units and `META_CANDI_NUM-1` meta units. For every pass it stamps the head/meta beat stream with valid/shift/first tags and supplies the per-pass shift amounts. It sits between the parse-step lookup logic and the shift stage in each parser pipeline stage.

## Interface
Parameters:
- `HEAD_CANDI_NUM`, 32: head shift candidates; max head units per pass = 31.
- `META_CANDI_NUM`, 16: meta shift candidates; max meta units per pass = 15.
- `HEAD_SHIFT_WIDTH`, 5: $clog2(HEAD_CANDI_NUM).
- `META_SHIFT_WIDTH`, 4: $clog2(META_CANDI_NUM).
- `LEN_WIDTH`, 10: request length width, in units.
- `NUM_BEATS`, 4: data beats per pass, ≥1.

Ports:
- `i_clk`  in  1  clock; one clock domain.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_req_valid`  in  1  request present.
- `o_req_ready`  out  1  high only in IDLE.
- `i_req_head_len`  in  LEN_WIDTH  head units to consume.
- `i_req_meta_len`  in  LEN_WIDTH  meta units to consume.
- `i_beat_valid`  in  1  a head/meta beat is present this cycle.
- `o_tag_valid`, `o_tag_shift`, `o_tag_first`  out  1 each  tag for the current beat.
- `o_headShift`  out  HEAD_SHIFT_WIDTH  head shift amount for the current pass.
- `o_metaShift`  out  META_SHIFT_WIDTH  meta shift amount for the current pass.
- `o_busy`  out  1  state ≠ IDLE.
- `o_done`  out  1  one-cycle pulse when the request completes.

## Operation
- States: IDLE, FIRST, DATA, DONE.
- **IDLE.** `o_req_ready`=1. On `i_req_valid`: latch `rem_h`=`i_req_head_len` and `rem_m`=`i_req_meta_len`.
  - Both lengths 0: go to DONE.
  - Otherwise: go to FIRST.
- **Pass amounts.** `hs` = min(`rem_h`, HEAD_CANDI_NUM-1) and `ms` = min(`rem_m`, META_CANDI_NUM-1). Both are registered on entry to FIRST and held for the whole pass.
- **FIRST.** The tag is {valid, shift, first}, with `o_headShift`=`hs` and `o_metaShift`=`ms`.
  - On `i_beat_valid`: `rem_h` -= `hs`, `rem_m` -= `ms`, beat counter := 0, go to DATA.
- **DATA.** The tag is {valid, shift, ~first}, with shift amounts held.
  - Each `i_beat_valid` increments the beat counter.
  - On beat NUM_BEATS-1: if `rem_h`|`rem_m` ≠ 0, go to FIRST (next pass); otherwise go to DONE.
- **DONE.** `o_done`=1 for one cycle, then IDLE.
- **Tag gating.** Tag outputs are `i_beat_valid` gated by state ∈ {FIRST, DATA}. They are combinational from registered state. All are 0 otherwise.
- **Idle shift values.** Shift outputs are 0 in IDLE and DONE.
- **Stalls.** With `i_beat_valid`=0, state, counters and shift registers hold. No beat is lost or duplicated.
- **Subtraction.** `rem_*` subtraction never underflows, because `hs` ≤ `rem_h` and `ms` ≤ `rem_m`.
- **Asymmetric lengths.** A pass where one side's remainder is 0 issues shift 0 for that side.
- **Pass count.** Passes = max(ceil(head_len/31), ceil(meta_len/15)).

## Timing
- **Reset values.** All outputs 0 except `o_req_ready`=1. State is IDLE and `rem_*`=0.
- **Reset mid-operation.** Asynchronous reset in any state returns to IDLE immediately. There is no `o_done` for the aborted request.
- **Request handshake.** Accept on `i_req_valid` & `o_req_ready`. FIRST is active the next cycle.
- **Latency.** Minimum accept-to-`o_done` = 1 + passes × (1+NUM_BEATS) cycles with continuous beats. For zero-length requests it is 1 cycle, and `o_done` appears in the cycle after accept.
- **Back-to-back requests.** A new request is accepted no earlier than the cycle after `o_done`. At most one request is outstanding.

## Structure
- Shared parser package holds:
  - TAG_VALID_BIT/TAG_SHIFT_BIT/TAG_FIRST_BIT.
  - TAG_WIDTH.
  - The state enum `shift_sched_state_t`.
- Sub-module `hdr_shift_pass_calc`: pure combinational min/subtract for one side (head or meta). It is instantiated twice, with the width parameterised.
- Everything else lives in one always_ff plus the output-gating logic.

## Test plan
Default parameters, `i_beat_valid`=1 unless stated.
- **Single pass.** head=20, meta=5 → one FIRST beat with shifts 20/5, then 4 DATA beats. `o_done` 6 cycles after accept.
- **Multi-pass.** head=70, meta=0 → head shifts 31, 31, 8 with meta shift 0 on each pass; 15 tagged beats; `o_done` after 16 cycles.
- **Meta-dominated.** head=10, meta=40 → passes (10,15), (0,15), (0,10).
- **Zero length.** head=0, meta=0 → no tag_valid; `o_done` the cycle after accept; ready returns high.
- **Beat gaps.** Drop `i_beat_valid` for 3 cycles mid-DATA → tags low during the gap; beat count and shift amounts unchanged; total still 5 tagged beats per pass.
- **Reset mid-pass.** Assert `i_rst_n`=0 in pass 2 of head=70 → outputs zero at once; `o_req_ready`=1 after release; a new head=20 request completes normally.

Source files
------------

// File: rtl/hdr_shift_sched_pkg.sv
// rtl/hdr_shift_sched_pkg.sv - shared tag layout and state encoding for the head/meta shift scheduler
package hdr_shift_sched_pkg;

   localparam int TAG_WIDTH     = 3;
   localparam int TAG_VALID_BIT = 2;
   localparam int TAG_SHIFT_BIT = 1;
   localparam int TAG_FIRST_BIT = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FIRST,
      ST_DATA,
      ST_DONE
   } shift_sched_state_t;

   // A single-beat pass still needs a one-bit counter.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/hdr_shift_pass_calc.sv
// rtl/hdr_shift_pass_calc.sv - per-side pass amount (min of remainder and pass limit) and the remainder after that pass
module hdr_shift_pass_calc
   import hdr_shift_sched_pkg::*;
#(
   parameter int LEN_WIDTH   = 10,
   parameter int SHIFT_WIDTH = 5,
   parameter int MAX_AMT     = 31
) (
   input  logic [LEN_WIDTH-1:0]   i_rem,
   output logic [SHIFT_WIDTH-1:0] o_amt,
   output logic [LEN_WIDTH-1:0]   o_rem_next
);

   logic [LEN_WIDTH-1:0] max_len;

   assign max_len = LEN_WIDTH'(MAX_AMT);

   // The amount never exceeds the remainder, so the subtraction cannot wrap.
   always_comb begin
      if (i_rem > max_len) begin
         o_amt = SHIFT_WIDTH'(MAX_AMT);
      end else begin
         o_amt = SHIFT_WIDTH'(i_rem);
      end
      o_rem_next = i_rem - LEN_WIDTH'(o_amt);
   end

endmodule

// File: rtl/hdr_shift_sched.sv
// rtl/hdr_shift_sched.sv - splits a head/meta shift request into passes and tags the beat stream of each pass
module hdr_shift_sched
   import hdr_shift_sched_pkg::*;
#(
   parameter int HEAD_CANDI_NUM   = 32,
   parameter int META_CANDI_NUM   = 16,
   parameter int HEAD_SHIFT_WIDTH = 5,
   parameter int META_SHIFT_WIDTH = 4,
   parameter int LEN_WIDTH        = 10,
   parameter int NUM_BEATS        = 4
) (
   input  logic                        i_clk,
   input  logic                        i_rst_n,
   input  logic                        i_req_valid,
   output logic                        o_req_ready,
   input  logic [LEN_WIDTH-1:0]        i_req_head_len,
   input  logic [LEN_WIDTH-1:0]        i_req_meta_len,
   input  logic                        i_beat_valid,
   output logic                        o_tag_valid,
   output logic                        o_tag_shift,
   output logic                        o_tag_first,
   output logic [HEAD_SHIFT_WIDTH-1:0] o_headShift,
   output logic [META_SHIFT_WIDTH-1:0] o_metaShift,
   output logic                        o_busy,
   output logic                        o_done
);

   localparam int                   CNT_WIDTH = cnt_width(NUM_BEATS);
   localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(NUM_BEATS - 1);

   shift_sched_state_t          state_q, state_d;
   logic [LEN_WIDTH-1:0]        rem_h_q, rem_h_d;
   logic [LEN_WIDTH-1:0]        rem_m_q, rem_m_d;
   logic [HEAD_SHIFT_WIDTH-1:0] hs_q, hs_d;
   logic [META_SHIFT_WIDTH-1:0] ms_q, ms_d;
   logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;

   logic [LEN_WIDTH-1:0]        calc_h_in, calc_m_in;
   logic [LEN_WIDTH-1:0]        h_rem_next, m_rem_next;
   logic [HEAD_SHIFT_WIDTH-1:0] h_amt;
   logic [META_SHIFT_WIDTH-1:0] m_amt;
   logic [TAG_WIDTH-1:0]        tag;
   logic                        active;

   // In IDLE the calculators see the incoming request so the first pass amounts load on accept.
   assign calc_h_in = (state_q == ST_IDLE) ? i_req_head_len : rem_h_q;
   assign calc_m_in = (state_q == ST_IDLE) ? i_req_meta_len : rem_m_q;

   hdr_shift_pass_calc #(
      .LEN_WIDTH  (LEN_WIDTH),
      .SHIFT_WIDTH(HEAD_SHIFT_WIDTH),
      .MAX_AMT    (HEAD_CANDI_NUM - 1)
   ) u_head_calc (
      .i_rem     (calc_h_in),
      .o_amt     (h_amt),
      .o_rem_next(h_rem_next)
   );

   hdr_shift_pass_calc #(
      .LEN_WIDTH  (LEN_WIDTH),
      .SHIFT_WIDTH(META_SHIFT_WIDTH),
      .MAX_AMT    (META_CANDI_NUM - 1)
   ) u_meta_calc (
      .i_rem     (calc_m_in),
      .o_amt     (m_amt),
      .o_rem_next(m_rem_next)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         rem_h_q <= '0;
         rem_m_q <= '0;
         hs_q    <= '0;
         ms_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         rem_h_q <= rem_h_d;
         rem_m_q <= rem_m_d;
         hs_q    <= hs_d;
         ms_q    <= ms_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rem_h_d = rem_h_q;
      rem_m_d = rem_m_q;
      hs_d    = hs_q;
      ms_d    = ms_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (i_req_valid) begin
               rem_h_d = i_req_head_len;
               rem_m_d = i_req_meta_len;
               hs_d    = h_amt;
               ms_d    = m_amt;
               if ((i_req_head_len == '0) && (i_req_meta_len == '0)) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_FIRST;
               end
            end
         end
         ST_FIRST: begin
            // Here the calculators see rem_*_q, so their amounts equal hs_q/ms_q.
            if (i_beat_valid) begin
               rem_h_d = h_rem_next;
               rem_m_d = m_rem_next;
               cnt_d   = '0;
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            if (i_beat_valid) begin
               if (cnt_q == LAST_BEAT) begin
                  cnt_d = '0;
                  if ((rem_h_q != '0) || (rem_m_q != '0)) begin
                     hs_d    = h_amt;
                     ms_d    = m_amt;
                     state_d = ST_FIRST;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign active = (state_q == ST_FIRST) || (state_q == ST_DATA);

   always_comb begin
      tag = '0;
      if (active) begin
         tag[TAG_VALID_BIT] = i_beat_valid;
         tag[TAG_SHIFT_BIT] = i_beat_valid;
         tag[TAG_FIRST_BIT] = i_beat_valid && (state_q == ST_FIRST);
      end
   end

   assign o_tag_valid = tag[TAG_VALID_BIT];
   assign o_tag_shift = tag[TAG_SHIFT_BIT];
   assign o_tag_first = tag[TAG_FIRST_BIT];
   assign o_headShift = active ? hs_q : '0;
   assign o_metaShift = active ? ms_q : '0;
   assign o_req_ready = (state_q == ST_IDLE);
   assign o_busy      = (state_q != ST_IDLE);
   assign o_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_hdr_shift_sched.sv
// tb/tb_hdr_shift_sched.sv - directed self-checking bench for hdr_shift_sched
module tb_hdr_shift_sched;

   localparam int HEAD_CANDI_NUM   = 32;
   localparam int META_CANDI_NUM   = 16;
   localparam int HEAD_SHIFT_WIDTH = 5;
   localparam int META_SHIFT_WIDTH = 4;
   localparam int LEN_WIDTH        = 10;
   localparam int NUM_BEATS        = 4;

   logic                        i_clk = 1'b0;
   logic                        i_rst_n = 1'b0;
   logic                        i_req_valid = 1'b0;
   logic                        o_req_ready;
   logic [LEN_WIDTH-1:0]        i_req_head_len = '0;
   logic [LEN_WIDTH-1:0]        i_req_meta_len = '0;
   logic                        i_beat_valid = 1'b1;
   logic                        o_tag_valid;
   logic                        o_tag_shift;
   logic                        o_tag_first;
   logic [HEAD_SHIFT_WIDTH-1:0] o_headShift;
   logic [META_SHIFT_WIDTH-1:0] o_metaShift;
   logic                        o_busy;
   logic                        o_done;

   int checks = 0;
   int failures = 0;

   int obs_beats, obs_pass, obs_done_cyc, obs_bad;
   int obs_ready_req, obs_ready_done, obs_ready_after, obs_done_after;
   int obs_hs[8];
   int obs_ms[8];

   hdr_shift_sched #(
      .HEAD_CANDI_NUM  (HEAD_CANDI_NUM),
      .META_CANDI_NUM  (META_CANDI_NUM),
      .HEAD_SHIFT_WIDTH(HEAD_SHIFT_WIDTH),
      .META_SHIFT_WIDTH(META_SHIFT_WIDTH),
      .LEN_WIDTH       (LEN_WIDTH),
      .NUM_BEATS       (NUM_BEATS)
   ) dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_req_valid   (i_req_valid),
      .o_req_ready   (o_req_ready),
      .i_req_head_len(i_req_head_len),
      .i_req_meta_len(i_req_meta_len),
      .i_beat_valid  (i_beat_valid),
      .o_tag_valid   (o_tag_valid),
      .o_tag_shift   (o_tag_shift),
      .o_tag_first   (o_tag_first),
      .o_headShift   (o_headShift),
      .o_metaShift   (o_metaShift),
      .o_busy        (o_busy),
      .o_done        (o_done)
   );

   always #5 i_clk = ~i_clk;

   // Drives one request (caller is just past a negedge) and records what the DUT shows each cycle.
   // Cycle 1 is the cycle after the accepting edge; gap cycles drop i_beat_valid.
   task automatic run_req(input int h, input int m, input int gap_start, input int gap_len);
      int cyc;
      int cur_h;
      int cur_m;
      obs_beats = 0; obs_pass = 0; obs_done_cyc = -1; obs_bad = 0;
      cur_h = -1; cur_m = -1;
      for (int i = 0; i < 8; i++) begin
         obs_hs[i] = -1;
         obs_ms[i] = -1;
      end
      i_req_valid    = 1'b1;
      i_req_head_len = LEN_WIDTH'(h);
      i_req_meta_len = LEN_WIDTH'(m);
      i_beat_valid   = 1'b1;
      #1;
      obs_ready_req = int'(o_req_ready);
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b0;
      cyc = 0;
      while (cyc < 300) begin
         @(negedge i_clk);
         cyc++;
         i_beat_valid = !((gap_start > 0) && (cyc >= gap_start) && (cyc < gap_start + gap_len));
         #1;
         if (o_tag_valid) obs_beats++;
         if (o_tag_valid != o_tag_shift) obs_bad++;
         if (!i_beat_valid && (o_tag_valid || o_tag_shift || o_tag_first)) obs_bad++;
         if (o_tag_first) begin
            cur_h = int'(o_headShift);
            cur_m = int'(o_metaShift);
            if (obs_pass < 8) begin
               obs_hs[obs_pass] = cur_h;
               obs_ms[obs_pass] = cur_m;
            end
            obs_pass++;
         end else if (o_busy && !o_done && (obs_pass > 0) &&
                      ((int'(o_headShift) != cur_h) || (int'(o_metaShift) != cur_m))) begin
            obs_bad++;
         end
         if (o_done) begin
            obs_done_cyc   = cyc;
            obs_ready_done = int'(o_req_ready);
            if ((o_headShift != '0) || (o_metaShift != '0) || o_tag_valid) obs_bad++;
            break;
         end
      end
      i_beat_valid = 1'b1;
      @(negedge i_clk);
      #1;
      obs_done_after  = int'(o_done);
      obs_ready_after = int'(o_req_ready);
   endtask

   task automatic test_reset();
      @(negedge i_clk);
      #1;
      checks++; if (o_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", o_req_ready); end
      checks++; if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", o_busy); end
      checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", o_done); end
      checks++; if ({o_tag_valid, o_tag_shift, o_tag_first} !== 3'b000) begin failures++; $display("FAIL reset_tags got=%03b exp=000", {o_tag_valid, o_tag_shift, o_tag_first}); end
      checks++; if ((o_headShift !== '0) || (o_metaShift !== '0)) begin failures++; $display("FAIL reset_shifts got=%0d/%0d exp=0/0", o_headShift, o_metaShift); end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      checks++; if (o_tag_valid !== 1'b0) begin failures++; $display("FAIL idle_tag_gated got=%0b exp=0", o_tag_valid); end
   endtask

   task automatic test_single_pass();
      run_req(20, 5, 0, 0);
      checks++; if (obs_ready_req != 1) begin failures++; $display("FAIL single_ready_req got=%0d exp=1", obs_ready_req); end
      checks++; if (obs_pass != 1) begin failures++; $display("FAIL single_passes got=%0d exp=1", obs_pass); end
      checks++; if ((obs_hs[0] != 20) || (obs_ms[0] != 5)) begin failures++; $display("FAIL single_shift got=%0d/%0d exp=20/5", obs_hs[0], obs_ms[0]); end
      checks++; if (obs_beats != 5) begin failures++; $display("FAIL single_beats got=%0d exp=5", obs_beats); end
      checks++; if (obs_done_cyc != 6) begin failures++; $display("FAIL single_done_cyc got=%0d exp=6", obs_done_cyc); end
      checks++; if (obs_bad != 0) begin failures++; $display("FAIL single_tag_rules got=%0d exp=0", obs_bad); end
      checks++; if (obs_ready_done != 0) begin failures++; $display("FAIL single_ready_in_done got=%0d exp=0", obs_ready_done); end
      checks++; if ((obs_done_after != 0) || (obs_ready_after != 1)) begin failures++; $display("FAIL single_after got=done%0d/ready%0d exp=done0/ready1", obs_done_after, obs_ready_after); end
   endtask

   task automatic test_multi_pass();
      run_req(70, 0, 0, 0);
      checks++; if (obs_pass != 3) begin failures++; $display("FAIL multi_passes got=%0d exp=3", obs_pass); end
      checks++; if ((obs_hs[0] != 31) || (obs_hs[1] != 31) || (obs_hs[2] != 8)) begin failures++; $display("FAIL multi_head got=%0d,%0d,%0d exp=31,31,8", obs_hs[0], obs_hs[1], obs_hs[2]); end
      checks++; if ((obs_ms[0] != 0) || (obs_ms[1] != 0) || (obs_ms[2] != 0)) begin failures++; $display("FAIL multi_meta got=%0d,%0d,%0d exp=0,0,0", obs_ms[0], obs_ms[1], obs_ms[2]); end
      checks++; if (obs_beats != 15) begin failures++; $display("FAIL multi_beats got=%0d exp=15", obs_beats); end
      checks++; if (obs_done_cyc != 16) begin failures++; $display("FAIL multi_done_cyc got=%0d exp=16", obs_done_cyc); end
      checks++; if (obs_bad != 0) begin failures++; $display("FAIL multi_tag_rules got=%0d exp=0", obs_bad); end
   endtask

   task automatic test_meta_dominated();
      run_req(10, 40, 0, 0);
      checks++; if (obs_pass != 3) begin failures++; $display("FAIL meta_passes got=%0d exp=3", obs_pass); end
      checks++; if ((obs_hs[0] != 10) || (obs_hs[1] != 0) || (obs_hs[2] != 0)) begin failures++; $display("FAIL meta_head got=%0d,%0d,%0d exp=10,0,0", obs_hs[0], obs_hs[1], obs_hs[2]); end
      checks++; if ((obs_ms[0] != 15) || (obs_ms[1] != 15) || (obs_ms[2] != 10)) begin failures++; $display("FAIL meta_meta got=%0d,%0d,%0d exp=15,15,10", obs_ms[0], obs_ms[1], obs_ms[2]); end
      checks++; if (obs_done_cyc != 16) begin failures++; $display("FAIL meta_done_cyc got=%0d exp=16", obs_done_cyc); end
   endtask

   task automatic test_zero_length();
      run_req(0, 0, 0, 0);
      checks++; if (obs_beats != 0) begin failures++; $display("FAIL zero_beats got=%0d exp=0", obs_beats); end
      checks++; if (obs_done_cyc != 1) begin failures++; $display("FAIL zero_done_cyc got=%0d exp=1", obs_done_cyc); end
      checks++; if (obs_ready_after != 1) begin failures++; $display("FAIL zero_ready_after got=%0d exp=1", obs_ready_after); end
   endtask

   task automatic test_boundary();
      run_req(31, 15, 0, 0);
      checks++; if ((obs_pass != 1) || (obs_hs[0] != 31) || (obs_ms[0] != 15)) begin failures++; $display("FAIL bound_max got=p%0d %0d/%0d exp=p1 31/15", obs_pass, obs_hs[0], obs_ms[0]); end
      checks++; if (obs_done_cyc != 6) begin failures++; $display("FAIL bound_max_done got=%0d exp=6", obs_done_cyc); end
      run_req(32, 16, 0, 0);
      checks++; if (obs_pass != 2) begin failures++; $display("FAIL bound_over_passes got=%0d exp=2", obs_pass); end
      checks++; if ((obs_hs[1] != 1) || (obs_ms[1] != 1)) begin failures++; $display("FAIL bound_over_tail got=%0d/%0d exp=1/1", obs_hs[1], obs_ms[1]); end
      checks++; if (obs_done_cyc != 11) begin failures++; $display("FAIL bound_over_done got=%0d exp=11", obs_done_cyc); end
   endtask

   task automatic test_beat_gaps();
      run_req(20, 5, 3, 3);
      checks++; if (obs_beats != 5) begin failures++; $display("FAIL gap_beats got=%0d exp=5", obs_beats); end
      checks++; if ((obs_hs[0] != 20) || (obs_ms[0] != 5)) begin failures++; $display("FAIL gap_shift got=%0d/%0d exp=20/5", obs_hs[0], obs_ms[0]); end
      checks++; if (obs_bad != 0) begin failures++; $display("FAIL gap_rules got=%0d exp=0", obs_bad); end
      checks++; if (obs_done_cyc != 9) begin failures++; $display("FAIL gap_done_cyc got=%0d exp=9", obs_done_cyc); end
   endtask

   task automatic test_back_to_back();
      run_req(20, 5, 0, 0);
      run_req(10, 40, 0, 0);
      checks++; if (obs_ready_req != 1) begin failures++; $display("FAIL b2b_ready got=%0d exp=1", obs_ready_req); end
      checks++; if ((obs_pass != 3) || (obs_done_cyc != 16)) begin failures++; $display("FAIL b2b_second got=p%0d d%0d exp=p3 d16", obs_pass, obs_done_cyc); end
   endtask

   task automatic test_reset_mid_pass();
      i_req_valid    = 1'b1;
      i_req_head_len = LEN_WIDTH'(70);
      i_req_meta_len = '0;
      i_beat_valid   = 1'b1;
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b0;
      repeat (7) @(negedge i_clk);
      #1;
      checks++; if ((o_headShift !== 5'd31) || (o_tag_first !== 1'b0)) begin failures++; $display("FAIL rst_pre_pass2 got=%0d/%0b exp=31/0", o_headShift, o_tag_first); end
      i_rst_n = 1'b0;
      #1;
      checks++; if ({o_tag_valid, o_tag_shift, o_tag_first} !== 3'b000) begin failures++; $display("FAIL rst_tags got=%03b exp=000", {o_tag_valid, o_tag_shift, o_tag_first}); end
      checks++; if ((o_headShift !== '0) || (o_busy !== 1'b0) || (o_done !== 1'b0)) begin failures++; $display("FAIL rst_outputs got=%0d/%0b/%0b exp=0/0/0", o_headShift, o_busy, o_done); end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      #1;
      checks++; if (o_req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b exp=1", o_req_ready); end
      @(negedge i_clk);
      #1;
      checks++; if ((o_done !== 1'b0) || (o_busy !== 1'b0)) begin failures++; $display("FAIL rst_no_done got=%0b/%0b exp=0/0", o_done, o_busy); end
      run_req(20, 5, 0, 0);
      checks++; if ((obs_done_cyc != 6) || (obs_beats != 5) || (obs_hs[0] != 20)) begin failures++; $display("FAIL rst_recover got=d%0d b%0d h%0d exp=d6 b5 h20", obs_done_cyc, obs_beats, obs_hs[0]); end
   endtask

   initial begin
      test_reset();
      test_single_pass();
      test_multi_pass();
      test_meta_dominated();
      test_zero_length();
      test_boundary();
      test_beat_gaps();
      test_back_to_back();
      test_reset_mid_pass();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
